mem_arb_2to1: RTL and testbench
===============================

// Module: mem_arb_2to1
// PURPOSE
//  Two-port request arbiter placed directly upstream of the single 4B sync-read RAM wrapper.
//  Merges port 0 (imem) and port 1 (dmem) val/rdy request streams onto one mem port.
//  Steers each in-order response back to its originating port.
//  Restores the request opaque field; the RAM drives resp opaque = 0.
// PARAMETERS
//  MAX_INFLIGHT  2  max accepted-but-unanswered requests (>=1; tag FIFO depth)
//  OPAQUE_W      8  width of mem_req_4B_t.opaque, saved per request
// PORTS
//  clk           in   1     clock; all state updates on posedge
//  rst           in   1     synchronous, active-high reset
//  p0_req_msg    in   mem_req_4B_t   port 0 request
//  p0_req_val    in   1     port 0 request valid
//  p0_req_rdy    out  1     port 0 request accepted this cycle if val
//  p0_resp_msg   out  mem_resp_4B_t  port 0 response (opaque restored)
//  p0_resp_val   out  1     port 0 response valid
//  p0_resp_rdy   in   1     port 0 response ready
//  p1_*          --   --    identical set for port 1
//  mem_req_msg   out  mem_req_4B_t   to RAM wrapper
//  mem_req_val   out  1     to RAM wrapper
//  mem_req_rdy   in   1     from RAM wrapper
//  mem_resp_msg  in   mem_resp_4B_t  from RAM wrapper
//  mem_resp_val  in   1     from RAM wrapper
//  mem_resp_rdy  out  1     to RAM wrapper
//  orphan_err    out  1     sticky: response arrived with no request outstanding
// BEHAVIOUR
//  State: last_grant (1b), tag FIFO of MAX_INFLIGHT x {port(1b), opaque}, count, rd/wr pointers.
//  Reset: last_grant=1 (port 0 wins first tie), count=0, pointers=0, orphan_err=0.
//  Outputs during/after reset:
//   - all *_val/*_rdy outputs 0 while count=0 and no input val.
//   - pX_resp_val = 0 while count = 0.
//  Request path, combinational, 0-cycle latency:
//   - full = (count == MAX_INFLIGHT).
//   - Grant: if !full and exactly one pX_req_val is high, grant that port.
//   - If both are high, grant the port != last_grant (round-robin).
//   - mem_req_val = granted; mem_req_msg = granted port's msg, passed unmodified.
//   - pX_req_rdy = (grant==X) && mem_req_rdy; the loser's rdy = 0.
//   - When full, grant and mem_req_val = 0 even if a pop occurs the same cycle. No resp->req comb path.
//   - On mem req handshake:
//     - push {grant, req.opaque}; wr_ptr wraps MAX_INFLIGHT-1 -> 0.
//     - last_grant <= grant.
//   - last_grant is unchanged on cycles with no handshake.
//   - req_val never depends on req_rdy.
//  Response path, combinational, in order:
//   - head = FIFO[rd_ptr].
//   - pX_resp_val = mem_resp_val && count!=0 && head.port==X.
//   - pX_resp_msg = mem_resp_msg with opaque := head.opaque.
//   - mem_resp_rdy = count!=0 && (head.port ? p1_resp_rdy : p0_resp_rdy).
//   - On mem resp handshake: pop; rd_ptr wraps.
//   - Backpressure on the head port stalls all responses (head-of-line); other port sees val=0.
//   - If mem_resp_val && count==0: mem_resp_rdy=0, no port val, orphan_err <= 1 (cleared only by rst).
//  Count update:
//   - push && pop: unchanged.
//   - push only: +1; pop only: -1.
//   - Never exceeds MAX_INFLIGHT; never underflows.
//  Reset mid-operation:
//   - All outstanding tags are discarded; count=0.
//   - The RAM wrapper is reset on the same rst, so no stale response follows.
// TESTING
//  1 Single p0 read addr 0x10, p1 idle:
//    - mem_req_val same cycle, p0_req_rdy=1.
//    - Next cycle resp routed to p0 only, opaque=0x5A restored.
//  2 p0 and p1 valid every cycle, mem always ready, MAX_INFLIGHT=2, resp_rdy=1:
//    - Grants alternate 0,1,0,1... starting with 0.
//    - Responses land on matching ports.
//  3 p1_resp_rdy=0 with head tag=p1:
//    - mem_resp_rdy=0 and p0_resp_val=0.
//    - After 2 inflight, all req_rdy=0.
//    - Raise p1_resp_rdy -> drains in order.
//  4 FIFO full and pop in the same cycle -> no new grant that cycle; grant the following cycle.
//  5 Inject mem_resp_val with count=0 -> orphan_err=1 and no pX_resp_val; rst clears it.
//  6 Assert rst with 2 requests inflight -> next cycle count=0, all resp_val=0, p0 wins next tie.

Source files
------------

// File: rtl/mem_arb_2to1.sv
// Two-port val/rdy arbiter in front of the 4B sync-read RAM wrapper.
// Round-robin request merge, in-order response steering via a tag FIFO.
package mem_msg_pkg;
  localparam int MEM_OPAQUE_W = 8;

  typedef struct packed {
    logic [2:0]              typ;
    logic [MEM_OPAQUE_W-1:0] opaque;
    logic [31:0]             addr;
    logic [1:0]              len;
    logic [31:0]             data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]              typ;
    logic [MEM_OPAQUE_W-1:0] opaque;
    logic [1:0]              test;
    logic [1:0]              len;
    logic [31:0]             data;
  } mem_resp_4B_t;
endpackage

module mem_arb_2to1
  import mem_msg_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int OPAQUE_W     = MEM_OPAQUE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_4B_t  p0_req_msg,
  input  logic         p0_req_val,
  output logic         p0_req_rdy,
  output mem_resp_4B_t p0_resp_msg,
  output logic         p0_resp_val,
  input  logic         p0_resp_rdy,
  input  mem_req_4B_t  p1_req_msg,
  input  logic         p1_req_val,
  output logic         p1_req_rdy,
  output mem_resp_4B_t p1_resp_msg,
  output logic         p1_resp_val,
  input  logic         p1_resp_rdy,
  output mem_req_4B_t  mem_req_msg,
  output logic         mem_req_val,
  input  logic         mem_req_rdy,
  input  mem_resp_4B_t mem_resp_msg,
  input  logic         mem_resp_val,
  output logic         mem_resp_rdy,
  output logic         orphan_err
);

  localparam int PTR_W =
    (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic                port;
    logic [OPAQUE_W-1:0] opaque;
  } tag_t;

  tag_t             fifo [MAX_INFLIGHT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             last_grant;

  logic full;
  logic busy;
  logic gnt_val;
  logic gnt_port;
  logic push;
  logic pop;
  tag_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count == CNT_W'(MAX_INFLIGHT));
  assign busy = (count != '0);

  always_comb begin
    gnt_val  = 1'b0;
    gnt_port = 1'b0;
    if (!full) begin
      unique case (1'b1)
        (p0_req_val && !p1_req_val): begin
          gnt_val  = 1'b1;
          gnt_port = 1'b0;
        end
        (!p0_req_val && p1_req_val): begin
          gnt_val  = 1'b1;
          gnt_port = 1'b1;
        end
        (p0_req_val && p1_req_val): begin
          gnt_val  = 1'b1;
          gnt_port = ~last_grant;
        end
        default: ;
      endcase
    end
  end

  assign mem_req_val = gnt_val;
  assign mem_req_msg = gnt_port ? p1_req_msg : p0_req_msg;
  assign p0_req_rdy  = gnt_val && !gnt_port && mem_req_rdy;
  assign p1_req_rdy  = gnt_val && gnt_port && mem_req_rdy;
  assign push        = gnt_val && mem_req_rdy;

  // Responses return in request order, so the FIFO head owns them.
  assign head = fifo[rd_ptr];

  assign p0_resp_val  = mem_resp_val && busy && !head.port;
  assign p1_resp_val  = mem_resp_val && busy && head.port;
  assign mem_resp_rdy =
    busy && (head.port ? p1_resp_rdy : p0_resp_rdy);
  assign pop = mem_resp_val && mem_resp_rdy;

  always_comb begin
    p0_resp_msg        = mem_resp_msg;
    p0_resp_msg.opaque = head.opaque;
    p1_resp_msg        = mem_resp_msg;
    p1_resp_msg.opaque = head.opaque;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{port: gnt_port, opaque: mem_req_msg.opaque};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      orphan_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= ptr_inc(wr_ptr);
        last_grant <= gnt_port;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (mem_resp_val && !busy) begin
        orphan_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Bench for mem_arb_2to1: RAM model, per-port expected-response queues,
// negedge monitor comparing routed responses against the queues.
module tb_mem_arb_2to1;
  import mem_msg_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  mem_req_4B_t  p0_req_msg;
  logic         p0_req_val;
  logic         p0_req_rdy;
  mem_resp_4B_t p0_resp_msg;
  logic         p0_resp_val;
  logic         p0_resp_rdy;
  mem_req_4B_t  p1_req_msg;
  logic         p1_req_val;
  logic         p1_req_rdy;
  mem_resp_4B_t p1_resp_msg;
  logic         p1_resp_val;
  logic         p1_resp_rdy;
  mem_req_4B_t  mem_req_msg;
  logic         mem_req_val;
  logic         mem_req_rdy;
  mem_resp_4B_t mem_resp_msg;
  logic         mem_resp_val;
  logic         mem_resp_rdy;
  logic         orphan_err;

  logic         ram_v;
  logic [31:0]  ram_data;
  logic         inj;
  logic [31:0]  ramq [$];

  int vectors     = 0;
  int miscompares = 0;

  mem_resp_4B_t exp0 [$];
  mem_resp_4B_t exp1 [$];

  always #5 clk = ~clk;

  mem_arb_2to1 dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req_msg   (p0_req_msg),
    .p0_req_val   (p0_req_val),
    .p0_req_rdy   (p0_req_rdy),
    .p0_resp_msg  (p0_resp_msg),
    .p0_resp_val  (p0_resp_val),
    .p0_resp_rdy  (p0_resp_rdy),
    .p1_req_msg   (p1_req_msg),
    .p1_req_val   (p1_req_val),
    .p1_req_rdy   (p1_req_rdy),
    .p1_resp_msg  (p1_resp_msg),
    .p1_resp_val  (p1_resp_val),
    .p1_resp_rdy  (p1_resp_rdy),
    .mem_req_msg  (mem_req_msg),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_resp_msg (mem_resp_msg),
    .mem_resp_val (mem_resp_val),
    .mem_resp_rdy (mem_resp_rdy),
    .orphan_err   (orphan_err)
  );

  function automatic logic [31:0] ramf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // RAM model: one-cycle sync read, opaque always 0.
  always @(posedge clk) begin
    if (rst) begin
      ramq.delete();
      ram_v    <= 1'b0;
      ram_data <= '0;
    end else begin
      if (ram_v && mem_resp_rdy && !inj) void'(ramq.pop_front());
      if (mem_req_val && mem_req_rdy) ramq.push_back(ramf(mem_req_msg.addr));
      ram_v <= (ramq.size() > 0);
      if (ramq.size() > 0) ram_data <= ramq[0];
    end
  end

  assign mem_resp_val = ram_v || inj;

  always_comb begin
    mem_resp_msg        = '0;
    mem_resp_msg.data   = inj ? 32'hDEAD_BEEF : ram_data;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every port response handshake.
  always @(negedge clk) begin : mon
    mem_resp_4B_t e;
    if (!rst) begin
      if (p0_resp_val && p0_resp_rdy) begin
        if (exp0.size() == 0) chk("p0_unexpected_resp", 1, 0);
        else begin
          e = exp0.pop_front();
          chk("p0_resp_data", p0_resp_msg.data, e.data);
          chk("p0_resp_opaque", 32'(p0_resp_msg.opaque), 32'(e.opaque));
        end
      end
      if (p1_resp_val && p1_resp_rdy) begin
        if (exp1.size() == 0) chk("p1_unexpected_resp", 1, 0);
        else begin
          e = exp1.pop_front();
          chk("p1_resp_data", p1_resp_msg.data, e.data);
          chk("p1_resp_opaque", 32'(p1_resp_msg.opaque), 32'(e.opaque));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit port, input logic [31:0] a,
                       input logic [7:0] op);
    mem_req_4B_t  m;
    mem_resp_4B_t r;
    m        = '0;
    m.opaque = op;
    m.addr   = a;
    r        = '0;
    r.opaque = op;
    r.data   = ramf(a);
    if (port) begin
      p1_req_msg = m;
      p1_req_val = 1'b1;
      exp1.push_back(r);
    end else begin
      p0_req_msg = m;
      p0_req_val = 1'b1;
      exp0.push_back(r);
    end
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    p0_req_val = 1'b0;
    p1_req_val = 1'b0;
    inj        = 1'b0;
    exp0.delete();
    exp1.delete();
    cyc();
    @(negedge clk);
    chk("rst_mem_req_val", 32'(mem_req_val), 0);
    chk("rst_req_rdy", {30'd0, p1_req_rdy, p0_req_rdy}, 0);
    chk("rst_resp_val", {30'd0, p1_resp_val, p0_resp_val}, 0);
    chk("rst_mem_resp_rdy", 32'(mem_resp_rdy), 0);
    chk("rst_orphan", 32'(orphan_err), 0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (exp0.size() + exp1.size()) != 0; k++)
      cyc();
    chk("drain_p0", exp0.size(), 0);
    chk("drain_p1", exp1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end

  initial begin
    bit exp_g;
    bit a0, a1;
    int i0, i1;
    p0_req_msg  = '0;
    p1_req_msg  = '0;
    p0_req_val  = 1'b0;
    p1_req_val  = 1'b0;
    p0_resp_rdy = 1'b1;
    p1_resp_rdy = 1'b1;
    mem_req_rdy = 1'b1;
    inj         = 1'b0;
    apply_reset();

    // single p0 request, response next cycle with opaque restored
    issue(0, 32'h10, 8'h5A);
    @(negedge clk);
    chk("t1_mem_req_val", 32'(mem_req_val), 1);
    chk("t1_p0_req_rdy", 32'(p0_req_rdy), 1);
    chk("t1_p1_req_rdy", 32'(p1_req_rdy), 0);
    chk("t1_mem_req_addr", mem_req_msg.addr, 32'h10);
    cyc();
    p0_req_val = 1'b0;
    @(negedge clk);
    chk("t1_p0_resp_val", 32'(p0_resp_val), 1);
    chk("t1_p1_resp_val", 32'(p1_resp_val), 0);
    drain();

    // both ports valid every cycle: round-robin from port 0
    apply_reset();
    exp_g = 1'b0;
    i0 = 0;
    i1 = 0;
    issue(0, 32'h100, 8'h10);
    issue(1, 32'h200, 8'h80);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_grant", {30'd0, p1_req_rdy, p0_req_rdy},
          exp_g ? 32'd2 : 32'd1);
      a0 = p0_req_rdy;
      a1 = p1_req_rdy;
      exp_g = ~exp_g;
      cyc();
      if (a0) begin
        i0++;
        if (i0 < 4) issue(0, 32'h100 + 32'(i0 * 4), 8'(8'h10 + i0));
        else p0_req_val = 1'b0;
      end
      if (a1) begin
        i1++;
        if (i1 < 4) issue(1, 32'h200 + 32'(i1 * 4), 8'(8'h80 + i1));
        else p1_req_val = 1'b0;
      end
    end
    p0_req_val = 1'b0;
    p1_req_val = 1'b0;
    drain();

    // head-of-line stall on p1, full FIFO, then pop while full
    apply_reset();
    p1_resp_rdy = 1'b0;
    issue(1, 32'h300, 8'h31);
    @(negedge clk);
    chk("t3_p1_req_rdy", 32'(p1_req_rdy), 1);
    cyc();
    p1_req_val = 1'b0;
    issue(0, 32'h304, 8'h32);
    @(negedge clk);
    chk("t3_p0_req_rdy", 32'(p0_req_rdy), 1);
    chk("t3_stall_mem_resp_rdy", 32'(mem_resp_rdy), 0);
    chk("t3_p0_resp_val", 32'(p0_resp_val), 0);
    chk("t3_p1_resp_val", 32'(p1_resp_val), 1);
    cyc();
    issue(0, 32'h308, 8'h33);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t3_full_p0_req_rdy", 32'(p0_req_rdy), 0);
      chk("t3_full_mem_req_val", 32'(mem_req_val), 0);
      chk("t3_full_mem_resp_rdy", 32'(mem_resp_rdy), 0);
      cyc();
    end
    p1_resp_rdy = 1'b1;
    @(negedge clk);
    chk("t4_pop_mem_resp_rdy", 32'(mem_resp_rdy), 1);
    chk("t4_pop_no_grant", 32'(mem_req_val), 0);
    chk("t4_pop_p0_req_rdy", 32'(p0_req_rdy), 0);
    cyc();
    @(negedge clk);
    chk("t4_next_grant", 32'(p0_req_rdy), 1);
    cyc();
    p0_req_val = 1'b0;
    drain();

    // orphan response with nothing outstanding
    cyc();
    inj = 1'b1;
    @(negedge clk);
    chk("t5_orphan_mem_resp_rdy", 32'(mem_resp_rdy), 0);
    chk("t5_orphan_resp_val", {30'd0, p1_resp_val, p0_resp_val}, 0);
    cyc();
    inj = 1'b0;
    @(negedge clk);
    chk("t5_orphan_set", 32'(orphan_err), 1);
    cyc();
    cyc();
    @(negedge clk);
    chk("t5_orphan_sticky", 32'(orphan_err), 1);
    apply_reset();

    // reset with two requests inflight, last grant was port 0
    p0_resp_rdy = 1'b0;
    p1_resp_rdy = 1'b0;
    issue(1, 32'h400, 8'h61);
    @(negedge clk);
    chk("t6_p1_req_rdy", 32'(p1_req_rdy), 1);
    cyc();
    p1_req_val = 1'b0;
    issue(0, 32'h404, 8'h62);
    @(negedge clk);
    chk("t6_p0_req_rdy", 32'(p0_req_rdy), 1);
    cyc();
    p0_req_val = 1'b0;
    @(negedge clk);
    chk("t6_head_p1_val", 32'(p1_resp_val), 1);
    rst = 1'b1;
    p0_resp_rdy = 1'b1;
    p1_resp_rdy = 1'b1;
    exp0.delete();
    exp1.delete();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_resp_val", {30'd0, p1_resp_val, p0_resp_val}, 0);
    chk("t6_count_zero", 32'(mem_resp_rdy), 0);
    cyc();
    issue(0, 32'h500, 8'h71);
    issue(1, 32'h504, 8'h72);
    @(negedge clk);
    chk("t6_tie_p0_wins", {30'd0, p1_req_rdy, p0_req_rdy}, 1);
    cyc();
    p0_req_val = 1'b0;
    @(negedge clk);
    chk("t6_then_p1", 32'(p1_req_rdy), 1);
    cyc();
    p1_req_val = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
